// File: rtl/pipelined_ripple_adder_if.sv
// Operand/result handshake bundle for the pipelined ripple-carry add/subtract unit.
interface pipelined_ripple_adder_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/pipelined_ripple_adder.sv
// Pipelined ripple-carry add/subtract: CHUNK bits of the carry chain resolved per stage,
// operands and partial sums travel with each beat, whole pipe stalls on output backpressure.
module pipelined_ripple_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input logic                    clk,
  input logic                    rst,
  pipelined_ripple_adder_if.slave bus
);
  localparam int unsigned STAGES = WIDTH / CHUNK;
  localparam int unsigned CW     = CHUNK + 1;

  if (CHUNK == 0 || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
    $error("pipelined_ripple_adder: WIDTH must be a non-zero multiple of CHUNK");
  end

  // One chunk of the ripple chain: returns {carry_out, chunk_sum} for slice k.
  function automatic logic [CW-1:0] chunk_add(input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y,
                                              input logic             c,
                                              input int unsigned      k);
    return CW'(x[k*CHUNK +: CHUNK]) + CW'(y[k*CHUNK +: CHUNK]) + CW'(c);
  endfunction

  // Per-stage registers; index STAGES-1 is the output register.
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];
  logic [STAGES-1:0] c_q;
  logic [STAGES-1:0] v_q;
  logic              ovf_q;

  // Stage inputs and stage results.
  logic [WIDTH-1:0]  a_i [STAGES];
  logic [WIDTH-1:0]  b_i [STAGES];
  logic [WIDTH-1:0]  s_i [STAGES];
  logic [STAGES-1:0] c_i;
  logic [STAGES-1:0] v_i;
  logic [WIDTH-1:0]  s_d [STAGES];
  logic [STAGES-1:0] c_d;
  logic              ovf_d;

  logic advance;

  assign advance       = !v_q[STAGES-1] || bus.out_ready;
  assign bus.in_ready  = advance;
  assign bus.out_valid = v_q[STAGES-1];
  assign bus.sum       = s_q[STAGES-1];
  assign bus.cout      = c_q[STAGES-1];
  assign bus.ovf       = ovf_q;

  // Stage 0 takes the ports (B inverted and carry forced for subtract); later stages the skewed regs.
  always_comb begin : stage_inputs
    a_i[0] = bus.a;
    b_i[0] = bus.sub ? ~bus.b : bus.b;
    c_i[0] = bus.sub | bus.cin;
    s_i[0] = '0;
    v_i[0] = bus.in_valid;
    for (int unsigned k = 1; k < STAGES; k++) begin
      a_i[k] = a_q[k-1];
      b_i[k] = b_q[k-1];
      c_i[k] = c_q[k-1];
      s_i[k] = s_q[k-1];
      v_i[k] = v_q[k-1];
    end
  end

  // Each stage fills its own sum slice; overflow is judged on the final stage's MSB.
  always_comb begin : stage_add
    logic [CW-1:0] t;
    t     = '0;
    ovf_d = 1'b0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      t                       = chunk_add(a_i[k], b_i[k], c_i[k], k);
      s_d[k]                  = s_i[k];
      s_d[k][k*CHUNK +: CHUNK] = t[CHUNK-1:0];
      c_d[k]                  = t[CHUNK];
    end
    ovf_d = (a_i[STAGES-1][WIDTH-1] == b_i[STAGES-1][WIDTH-1]) &&
            (s_d[STAGES-1][WIDTH-1] != a_i[STAGES-1][WIDTH-1]);
  end

  // Whole pipe shifts together; nothing moves while the output beat waits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q   <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else if (advance) begin
      v_q   <= v_i;
      c_q   <= c_d;
      ovf_q <= ovf_d;
      for (int unsigned k = 0; k < STAGES; k++) begin
        a_q[k] <= a_i[k];
        b_q[k] <= b_i[k];
        s_q[k] <= s_d[k];
      end
    end
  end
endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// Self-checking bench: arithmetic model + scoreboard on the 16/4 unit, directed checks on a 4/4 unit.
module tb_pipelined_ripple_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipelined_ripple_adder_if #(.WIDTH(16)) bus ();
  pipelined_ripple_adder_if #(.WIDTH(4))  bus4 ();

  pipelined_ripple_adder #(.WIDTH(16), .CHUNK(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  pipelined_ripple_adder #(.WIDTH(4),  .CHUNK(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

  typedef struct packed {
    logic [15:0] s;
    logic        c;
    logic        o;
  } res_t;

  res_t q[$];
  int   tests   = 0;
  int   fails   = 0;
  int   retired = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Plain integer arithmetic reference.
  function automatic res_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic c, input logic s);
    res_t r;
    int   sa, sb, full;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (s) begin
      full = int'({16'd0, a}) - int'({16'd0, b});
      r.c  = (a >= b);
      r.o  = ((sa - sb) > 32767) || ((sa - sb) < -32768);
    end else begin
      full = int'({16'd0, a}) + int'({16'd0, b}) + int'({31'd0, c});
      r.c  = (full > 65535);
      r.o  = ((sa + sb + int'({31'd0, c})) > 32767) || ((sa + sb + int'({31'd0, c})) < -32768);
    end
    r.s = full[15:0];
    return r;
  endfunction

  // Scoreboard: output beat must match the model's oldest pending result, held while stalled.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
    end else begin
      check("in_ready_rule", 32'(bus.in_ready), 32'(!bus.out_valid || bus.out_ready));
      if (bus.out_valid) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_result: got sum 0x%0h with nothing pending", bus.sum);
        end else begin
          check("sb_sum",  32'(bus.sum),  32'(q[0].s));
          check("sb_cout", 32'(bus.cout), 32'(q[0].c));
          check("sb_ovf",  32'(bus.ovf),  32'(q[0].o));
          if (bus.out_ready) begin
            void'(q.pop_front());
            retired++;
          end
        end
      end
      if (bus.in_valid && bus.in_ready)
        q.push_back(model(bus.a, bus.b, bus.cin, bus.sub));
    end
  end

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic c, input logic s);
    bit ok;
    ok         = 1'b0;
    bus.a      = a;
    bus.b      = b;
    bus.cin    = c;
    bus.sub    = s;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("accept_timeout", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // One beat on the 16-bit unit with literal expectations and latency in cycles.
  task automatic directed(input string name, input logic [15:0] a, input logic [15:0] b,
                          input logic c, input logic s,
                          input logic [15:0] es, input logic ec, input logic eo);
    int lat;
    send(a, b, c, s);
    lat = 1;
    while (lat < 20) begin
      @(negedge clk);
      if (bus.out_valid) break;
      @(posedge clk);
      lat++;
    end
    check({name, "_lat"},  32'(lat),      32'd4);
    check({name, "_sum"},  32'(bus.sum),  32'(es));
    check({name, "_cout"}, 32'(bus.cout), 32'(ec));
    check({name, "_ovf"},  32'(bus.ovf),  32'(eo));
    @(posedge clk);
    #1;
  endtask

  task automatic directed4(input string name, input logic [3:0] a, input logic [3:0] b,
                           input logic s, input logic [3:0] es, input logic ec, input logic eo);
    int lat;
    bus4.a = a;
    bus4.b = b;
    bus4.cin = 1'b0;
    bus4.sub = s;
    bus4.in_valid = 1'b1;
    @(negedge clk);
    check({name, "_in_ready"}, 32'(bus4.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus4.in_valid = 1'b0;
    lat = 1;
    while (lat < 20) begin
      @(negedge clk);
      if (bus4.out_valid) break;
      @(posedge clk);
      lat++;
    end
    check({name, "_lat"},  32'(lat),       32'd1);
    check({name, "_sum"},  32'(bus4.sum),  32'(es));
    check({name, "_cout"}, 32'(bus4.cout), 32'(ec));
    check({name, "_ovf"},  32'(bus4.ovf),  32'(eo));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int base, cnt;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b1;
    bus4.in_valid  = 1'b0;
    bus4.a         = '0;
    bus4.b         = '0;
    bus4.cin       = 1'b0;
    bus4.sub       = 1'b0;
    bus4.out_ready = 1'b1;

    // Reset state
    #12;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_sum",       32'(bus.sum),       32'd0);
    check("rst_cout",      32'(bus.cout),      32'd0);
    check("rst_ovf",       32'(bus.ovf),       32'd0);
    #8;
    rst = 1'b0;
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Directed arithmetic with hand-computed results
    directed("add_1_1",      16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);
    directed("add_ffff_1",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    directed("add_7fff_1",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    directed("sub_5_7",      16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    directed("add_cin",      16'h1234, 16'h0FFF, 1'b1, 1'b0, 16'h2234, 1'b0, 1'b0);
    directed("sub_cin_ign",  16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    directed("sub_equal",    16'hABCD, 16'hABCD, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);

    // Back-to-back burst with a 3-cycle downstream stall in the middle
    base = retired;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      end
      begin
        repeat (5) @(posedge clk);
        #2;
        bus.out_ready = 1'b0;
        @(negedge clk);
        check("stall_out_valid", 32'(bus.out_valid), 32'd1);
        check("stall_in_ready",  32'(bus.in_ready),  32'd0);
        repeat (3) @(posedge clk);
        #2;
        bus.out_ready = 1'b1;
      end
    join
    for (int i = 0; i < 50 && q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    check("burst_retired", 32'(retired - base), 32'd8);
    check("burst_drained", 32'(q.size()),       32'd0);
    @(posedge clk);
    #1;

    // Reset with three beats in flight
    send(16'h1111, 16'h2222, 1'b0, 1'b0);
    send(16'h3333, 16'h4444, 1'b0, 1'b0);
    send(16'h5555, 16'h6666, 1'b0, 1'b1);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.out_valid) cnt++;
    end
    check("midrst_no_stale", 32'(cnt), 32'd0);
    @(posedge clk);
    #1;

    // Single-stage configuration
    directed4("w4_9_8",  4'h9, 4'h8, 1'b0, 4'h1, 1'b1, 1'b1);
    directed4("w4_3m4",  4'h3, 4'h4, 1'b1, 4'hF, 1'b0, 1'b0);
    directed4("w4_8m1",  4'h8, 4'h1, 1'b1, 4'h7, 1'b1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1, "watchdog");
  end
endmodule
